// File: rtl/random_gen_pkg.sv
// Shared types and LFSR helpers for the pseudo-random DA LUT stimulus source.
// The tap masks encode the feedback polynomials used by every LFSR in the block.
package random_gen_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;

  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [31:0] LFSR32_TAPS = 32'h80200003;

  // One Fibonacci step; for width 16 the upper half of the result is forced to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int width);
    logic fb;
    if (width == 32) fb = ^(state & LFSR32_TAPS);
    else fb = ^(state[15:0] & LFSR16_TAPS);
    lfsr_next = {state[30:0], fb};
    if (width != 32) lfsr_next[31:16] = '0;
  endfunction

endpackage

// File: rtl/lfsr_frame_step.sv
// Combinational unroll of N LFSR steps, exposing the low OUT_W bits after each
// step and the final state so a whole frame is produced in one cycle.
module lfsr_frame_step
  import random_gen_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 7,
  parameter int OUT_W = 1
) (
  input  logic [W-1:0]       state_in,
  output logic [N*OUT_W-1:0] step_bits,
  output logic [W-1:0]       state_out
);

  logic [W-1:0] s;

  always_comb begin
    s = state_in;
    step_bits = '0;
    for (int i = 0; i < N; i++) begin
      s = W'(lfsr_next(32'(s), W));
      step_bits[i*OUT_W +: OUT_W] = s[OUT_W-1:0];
    end
    state_out = s;
  end

endmodule

// File: rtl/random_gen_stream.sv
// Ready/valid pseudo-random frame source: K-1 address bits and K signed weights
// per frame, with programmable frame count, runtime seeds and abort.
module random_gen_stream
  import random_gen_pkg::*;
#(
  parameter int          K            = 8,
  parameter int          DATA_WIDTH_B = 8,
  parameter int          LFSR_W       = 16,
  parameter logic [31:0] SEED_ADDR    = 32'h0000D348,
  parameter logic [31:0] SEED_B       = 32'h0000A562,
  parameter int          FRAME_CNT_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [FRAME_CNT_W-1:0]               num_frames,
  input  logic                                 abort,
  input  logic                                 seed_load,
  input  logic [LFSR_W-1:0]                    seed_addr_in,
  input  logic [LFSR_W-1:0]                    seed_b_in,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [K-2:0]                         addr_array,
  output logic [K-1:0][DATA_WIDTH_B-1:0]       B_temp,
  output logic [FRAME_CNT_W-1:0]               frame_idx,
  output logic                                 busy,
  output logic                                 gen_done
);

  if ((K % 4) != 0 || K < 4) begin : g_bad_k
    $fatal(1, "random_gen_stream: K must be a multiple of 4 and >= 4");
  end
  if (LFSR_W != 16 && LFSR_W != 32) begin : g_bad_lfsr_w
    $fatal(1, "random_gen_stream: LFSR_W must be 16 or 32");
  end
  if (DATA_WIDTH_B < 1 || DATA_WIDTH_B > LFSR_W || DATA_WIDTH_B > 16) begin : g_bad_data_w
    $fatal(1, "random_gen_stream: DATA_WIDTH_B out of range");
  end

  localparam logic [LFSR_W-1:0] RST_SEED_ADDR = SEED_ADDR[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] RST_SEED_B    = SEED_B[LFSR_W-1:0];

  // An all-zero state would lock the LFSR, so it is mapped to 1.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

  gen_state_t                state, next_state;
  logic [LFSR_W-1:0]         s_addr, s_b;
  logic [LFSR_W-1:0]         addr_base, b_base, addr_final, b_final;
  logic [K-2:0]              addr_bits;
  logic [K*DATA_WIDTH_B-1:0] b_bits;
  logic [FRAME_CNT_W-1:0]    num_frames_q;
  logic                      seed_ok, handshake, last_frame, launch, advance;

  // Fresh seeds bypass the state registers so a start in the same cycle uses them.
  assign seed_ok    = seed_load && (state != RUN);
  assign addr_base  = seed_ok ? fix_seed(seed_addr_in) : s_addr;
  assign b_base     = seed_ok ? fix_seed(seed_b_in) : s_b;
  assign handshake  = out_valid && out_ready;
  assign last_frame = (num_frames_q != '0) && (frame_idx == num_frames_q - FRAME_CNT_W'(1));
  assign launch     = start && !abort && (state != RUN);
  assign advance    = handshake && !abort && !last_frame;

  lfsr_frame_step #(.W(LFSR_W), .N(K-1), .OUT_W(1)) u_addr_step (
    .state_in  (addr_base),
    .step_bits (addr_bits),
    .state_out (addr_final)
  );

  lfsr_frame_step #(.W(LFSR_W), .N(K), .OUT_W(DATA_WIDTH_B)) u_b_step (
    .state_in  (b_base),
    .step_bits (b_bits),
    .state_out (b_final)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (launch) next_state = RUN;
      RUN: begin
        if (abort) next_state = IDLE;
        else if (handshake && last_frame) next_state = DONE;
      end
      DONE: begin
        if (abort) next_state = IDLE;
        else if (launch) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    gen_done  = (state == DONE);
  end

  // Frame data and LFSR states only move on launch or an accepted non-final frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_addr       <= RST_SEED_ADDR;
      s_b          <= RST_SEED_B;
      addr_array   <= '0;
      B_temp       <= '0;
      frame_idx    <= '0;
      num_frames_q <= '0;
    end else begin
      if (launch || advance) begin
        s_addr     <= addr_final;
        s_b        <= b_final;
        addr_array <= addr_bits;
        B_temp     <= b_bits;
      end else if (seed_ok) begin
        s_addr <= addr_base;
        s_b    <= b_base;
      end
      if (launch) begin
        frame_idx    <= '0;
        num_frames_q <= num_frames;
      end else if (advance) begin
        frame_idx <= frame_idx + FRAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_random_gen_stream.sv
// Self-checking bench for random_gen_stream: three parameterisations checked
// against an independent LFSR model through an expected-frame queue.
module tb_random_gen_stream;

  typedef struct packed {
    logic [15:0]       idx;
    logic [10:0]       addr;
    logic [11:0][15:0] w;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, abort, out_ready;
  logic        start_a, start_b, start_c;
  logic        seed_load_a, seed_load_b, seed_load_c;
  logic [15:0] num_frames;
  logic [31:0] seed_addr_in, seed_b_in;

  logic            out_valid_a, busy_a, gen_done_a;
  logic [6:0]      addr_array_a;
  logic [7:0][7:0] B_temp_a;
  logic [15:0]     frame_idx_a;

  logic            out_valid_b, busy_b, gen_done_b;
  logic [6:0]      addr_array_b;
  logic [7:0][7:0] B_temp_b;
  logic [3:0]      frame_idx_b;

  logic              out_valid_c, busy_c, gen_done_c;
  logic [10:0]       addr_array_c;
  logic [11:0][11:0] B_temp_c;
  logic [15:0]       frame_idx_c;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_addr, m_b;
  frame_t      sb[$];

  always #5 clk = ~clk;

  random_gen_stream dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_frames(num_frames), .abort(abort),
    .seed_load(seed_load_a), .seed_addr_in(seed_addr_in[15:0]), .seed_b_in(seed_b_in[15:0]),
    .out_ready(out_ready), .out_valid(out_valid_a), .addr_array(addr_array_a),
    .B_temp(B_temp_a), .frame_idx(frame_idx_a), .busy(busy_a), .gen_done(gen_done_a)
  );

  random_gen_stream #(.FRAME_CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_frames(num_frames[3:0]), .abort(abort),
    .seed_load(seed_load_b), .seed_addr_in(seed_addr_in[15:0]), .seed_b_in(seed_b_in[15:0]),
    .out_ready(out_ready), .out_valid(out_valid_b), .addr_array(addr_array_b),
    .B_temp(B_temp_b), .frame_idx(frame_idx_b), .busy(busy_b), .gen_done(gen_done_b)
  );

  random_gen_stream #(.K(12), .DATA_WIDTH_B(12), .LFSR_W(32)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .num_frames(num_frames), .abort(abort),
    .seed_load(seed_load_c), .seed_addr_in(seed_addr_in), .seed_b_in(seed_b_in),
    .out_ready(out_ready), .out_valid(out_valid_c), .addr_array(addr_array_c),
    .B_temp(B_temp_c), .frame_idx(frame_idx_c), .busy(busy_c), .gen_done(gen_done_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s, input int w);
    logic fb;
    if (w == 16) begin
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      m_step = {16'h0000, s[14:0], fb};
    end else begin
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      m_step = {s[30:0], fb};
    end
  endfunction

  task automatic model_next(input int k, input int dw, input int w, input int idx);
    frame_t f;
    f = '0;
    f.idx = 16'(idx);
    for (int i = 0; i < k - 1; i++) begin
      m_addr = m_step(m_addr, w);
      f.addr[i] = m_addr[0];
    end
    for (int i = 0; i < k; i++) begin
      m_b = m_step(m_b, w);
      f.w[i] = m_b[15:0] & 16'((32'd1 << dw) - 1);
    end
    sb.push_back(f);
  endtask

  function automatic logic [63:0] pack_a(input frame_t f);
    pack_a = '0;
    for (int i = 0; i < 8; i++) pack_a[i*8 +: 8] = f.w[i][7:0];
  endfunction

  function automatic logic [143:0] pack_c(input frame_t f);
    pack_c = '0;
    for (int i = 0; i < 12; i++) pack_c[i*12 +: 12] = f.w[i][11:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (gen_done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", gen_done_a); end
    checks++; if (addr_array_a !== 7'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", addr_array_a); end
    checks++; if (B_temp_a !== 64'd0) begin errors++; $display("[TB] FAIL reset_weights: got %h want 0", B_temp_a); end
    checks++; if (frame_idx_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d want 0", frame_idx_a); end
    checks++; if (out_valid_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_c: got %b want 0", out_valid_c); end
  endtask

  task automatic test_basic();
    frame_t e;
    int nvalid, pushed;
    m_addr = 32'hD348; m_b = 32'hA562; sb.delete();
    num_frames = 16'd3; out_ready = 1'b1; start_a = 1'b1;
    model_next(8, 8, 16, 0); pushed = 1;
    tick();
    start_a = 1'b0;
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL start_latency: valid=%b want 1", out_valid_a); end
    checks++; if (B_temp_a[0] !== 8'hC5) begin errors++; $display("[TB] FAIL frame0_w0: got %h want c5", B_temp_a[0]); end
    checks++; if (addr_array_a[0] !== 1'b0) begin errors++; $display("[TB] FAIL frame0_a0: got %b want 0", addr_array_a[0]); end
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_a) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL basic_extra_frame: idx=%0d want none", frame_idx_a); end
        else begin
          e = sb.pop_front();
          if (addr_array_a !== e.addr[6:0]) begin errors++; $display("[TB] FAIL basic_addr: got %h want %h", addr_array_a, e.addr[6:0]); end
          checks++; if (B_temp_a !== pack_a(e)) begin errors++; $display("[TB] FAIL basic_weights: got %h want %h", B_temp_a, pack_a(e)); end
          checks++; if (frame_idx_a !== e.idx) begin errors++; $display("[TB] FAIL basic_idx: got %0d want %0d", frame_idx_a, e.idx); end
          if (pushed < 3) begin model_next(8, 8, 16, pushed); pushed++; end
        end
      end
      tick();
    end
    checks++; if (nvalid != 3) begin errors++; $display("[TB] FAIL basic_valid_count: got %0d want 3", nvalid); end
    checks++; if (gen_done_a !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b want 1", gen_done_a); end
  endtask

  task automatic test_back_pressure();
    frame_t e;
    int hs, pushed;
    sb.delete();
    num_frames = 16'd10; out_ready = 1'b1; start_a = 1'b1;
    model_next(8, 8, 16, 0); pushed = 1;
    tick();
    start_a = 1'b0;
    hs = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (out_valid_a) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL bp_extra_frame: idx=%0d want none", frame_idx_a); end
        else begin
          e = sb[0];
          if (addr_array_a !== e.addr[6:0]) begin errors++; $display("[TB] FAIL bp_addr: got %h want %h", addr_array_a, e.addr[6:0]); end
          checks++; if (B_temp_a !== pack_a(e)) begin errors++; $display("[TB] FAIL bp_weights: got %h want %h", B_temp_a, pack_a(e)); end
          checks++; if (frame_idx_a !== e.idx) begin errors++; $display("[TB] FAIL bp_idx: got %0d want %0d", frame_idx_a, e.idx); end
          if (out_ready) begin
            sb.delete(0);
            hs++;
            if (pushed < 10) begin model_next(8, 8, 16, pushed); pushed++; end
          end
        end
      end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (hs != 10) begin errors++; $display("[TB] FAIL bp_handshakes: got %0d want 10", hs); end
    checks++; if (gen_done_a !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %b want 1", gen_done_a); end
  endtask

  task automatic test_seed_load();
    frame_t e;
    int nvalid, pushed;
    sb.delete();
    m_addr = 32'h1234; m_b = 32'h1;
    seed_addr_in = 32'h1234; seed_b_in = 32'h0; seed_load_a = 1'b1;
    num_frames = 16'd4; out_ready = 1'b1; start_a = 1'b1;
    model_next(8, 8, 16, 0); pushed = 1;
    tick();
    start_a = 1'b0; seed_load_a = 1'b0;
    checks++; if (B_temp_a[0] !== 8'h02) begin errors++; $display("[TB] FAIL seed_zero_w0: got %h want 02", B_temp_a[0]); end
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      seed_load_a = (c == 1);
      seed_b_in = 32'h00FF;
      if (out_valid_a) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL seed_extra_frame: idx=%0d want none", frame_idx_a); end
        else begin
          e = sb.pop_front();
          if (addr_array_a !== e.addr[6:0]) begin errors++; $display("[TB] FAIL seed_addr: got %h want %h", addr_array_a, e.addr[6:0]); end
          checks++; if (B_temp_a !== pack_a(e)) begin errors++; $display("[TB] FAIL seed_weights: got %h want %h", B_temp_a, pack_a(e)); end
          checks++; if (frame_idx_a !== e.idx) begin errors++; $display("[TB] FAIL seed_idx: got %0d want %0d", frame_idx_a, e.idx); end
          if (pushed < 4) begin model_next(8, 8, 16, pushed); pushed++; end
        end
      end
      tick();
    end
    seed_load_a = 1'b0;
    checks++; if (nvalid != 4) begin errors++; $display("[TB] FAIL seed_valid_count: got %0d want 4", nvalid); end
  endtask

  task automatic test_reset_midrun();
    frame_t e;
    num_frames = 16'd5; out_ready = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL midrun_stalled_valid: got %b want 1", out_valid_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midrun_rst_valid: got %b want 0", out_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midrun_rst_busy: got %b want 0", busy_a); end
    checks++; if (addr_array_a !== 7'd0) begin errors++; $display("[TB] FAIL midrun_rst_addr: got %h want 0", addr_array_a); end
    checks++; if (B_temp_a !== 64'd0) begin errors++; $display("[TB] FAIL midrun_rst_weights: got %h want 0", B_temp_a); end
    checks++; if (frame_idx_a !== 16'd0) begin errors++; $display("[TB] FAIL midrun_rst_idx: got %0d want 0", frame_idx_a); end
    m_addr = 32'hD348; m_b = 32'hA562; sb.delete();
    model_next(8, 8, 16, 0);
    e = sb.pop_front();
    num_frames = 16'd3; out_ready = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (addr_array_a !== e.addr[6:0]) begin errors++; $display("[TB] FAIL restart_addr: got %h want %h", addr_array_a, e.addr[6:0]); end
    checks++; if (B_temp_a !== pack_a(e)) begin errors++; $display("[TB] FAIL restart_weights: got %h want %h", B_temp_a, pack_a(e)); end
    checks++; if (B_temp_a[0] !== 8'hC5) begin errors++; $display("[TB] FAIL restart_w0: got %h want c5", B_temp_a[0]); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL restart_abort_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_free_run();
    frame_t e;
    m_addr = 32'hD348; m_b = 32'hA562; sb.delete();
    num_frames = 16'd0; out_ready = 1'b1; start_b = 1'b1;
    model_next(8, 8, 16, 0);
    tick();
    start_b = 1'b0;
    for (int h = 0; h < 20; h++) begin
      checks++;
      if (!out_valid_b || sb.size() == 0) begin errors++; $display("[TB] FAIL free_valid: got %b want 1 at handshake %0d", out_valid_b, h); end
      else begin
        e = sb.pop_front();
        if (addr_array_b !== e.addr[6:0]) begin errors++; $display("[TB] FAIL free_addr: got %h want %h", addr_array_b, e.addr[6:0]); end
        checks++; if (B_temp_b !== pack_a(e)) begin errors++; $display("[TB] FAIL free_weights: got %h want %h", B_temp_b, pack_a(e)); end
        checks++; if (frame_idx_b !== e.idx[3:0]) begin errors++; $display("[TB] FAIL free_idx: got %0d want %0d", frame_idx_b, e.idx[3:0]); end
        if (h < 19) model_next(8, 8, 16, h + 1);
      end
      if (h == 16) begin
        checks++; if (frame_idx_b !== 4'd0) begin errors++; $display("[TB] FAIL free_wrap: got %0d want 0", frame_idx_b); end
      end
      abort = (h == 19);
      tick();
    end
    abort = 1'b0;
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b want 0", out_valid_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy_b); end
    checks++; if (gen_done_b !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b want 0", gen_done_b); end
    abort = 1'b1; start_b = 1'b1;
    tick();
    abort = 1'b0; start_b = 1'b0;
    checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL abort_with_start_busy: got %b want 0", busy_b); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL abort_with_start_valid: got %b want 0", out_valid_b); end
  endtask

  task automatic test_lfsr32();
    frame_t e;
    int hs, pushed;
    logic zero_seen;
    m_addr = 32'hD348; m_b = 32'hA562; sb.delete();
    num_frames = 16'd1000; out_ready = 1'b1; start_c = 1'b1;
    model_next(12, 12, 32, 0); pushed = 1;
    tick();
    start_c = 1'b0;
    hs = 0; zero_seen = 1'b0;
    for (int c = 0; c < 1010; c++) begin
      if (dut_c.s_addr == 32'd0 || dut_c.s_b == 32'd0) zero_seen = 1'b1;
      if (out_valid_c) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL w32_extra_frame: idx=%0d want none", frame_idx_c); end
        else begin
          e = sb.pop_front();
          if (addr_array_c !== e.addr) begin errors++; $display("[TB] FAIL w32_addr: got %h want %h", addr_array_c, e.addr); end
          checks++; if (B_temp_c !== pack_c(e)) begin errors++; $display("[TB] FAIL w32_weights: got %h want %h", B_temp_c, pack_c(e)); end
          checks++; if (frame_idx_c !== e.idx) begin errors++; $display("[TB] FAIL w32_idx: got %0d want %0d", frame_idx_c, e.idx); end
          hs++;
          if (pushed < 1000) begin model_next(12, 12, 32, pushed); pushed++; end
        end
      end
      tick();
    end
    checks++; if (hs != 1000) begin errors++; $display("[TB] FAIL w32_handshakes: got %0d want 1000", hs); end
    checks++; if (gen_done_c !== 1'b1) begin errors++; $display("[TB] FAIL w32_done: got %b want 1", gen_done_c); end
    checks++; if (zero_seen !== 1'b0) begin errors++; $display("[TB] FAIL w32_zero_state: got %b want 0", zero_seen); end
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; out_ready = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    seed_load_a = 1'b0; seed_load_b = 1'b0; seed_load_c = 1'b0;
    num_frames = 16'd0; seed_addr_in = 32'd0; seed_b_in = 32'd0;
    $display("[TB] starting random_gen_stream bench");
    test_reset();
    test_basic();
    test_back_pressure();
    test_seed_load();
    test_reset_midrun();
    test_free_run();
    test_lfsr32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
